// File: rtl/mtimer_cluster.sv
// Memory-mapped 64-bit machine timer with prescaler and NUM_CMP compare channels.
// Reads are combinational; interrupts are registered level outputs.
module mtimer_cluster #(
   parameter int  NUM_CMP        = 2,
   parameter int  PRESCALE_WIDTH = 8,
   localparam int ADDR_WIDTH     = $clog2(4 + 2 * NUM_CMP)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rd_en,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [31:0]           wr_data,
   input  logic [3:0]            wr_strobe,
   output logic [31:0]           rd_data,
   output logic [NUM_CMP-1:0]    int_vec,
   output logic                  interrupt
);

   logic [63:0]               mtime_q, mtime_d;
   logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
   logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
   logic                      en_q, en_d;
   logic [NUM_CMP-1:0]        ie_q, ie_d;
   logic [NUM_CMP-1:0]        int_vec_q, int_vec_d;
   logic                      interrupt_q, interrupt_d;
   logic [31:0]               shadow_q, shadow_d;
   logic [63:0]               cmp_q [NUM_CMP];
   logic [63:0]               cmp_d [NUM_CMP];

   logic [NUM_CMP-1:0]        match_s;
   logic [31:0]               ctrl_s;
   logic [31:0]               ctrl_wr_s;
   logic [31:0]               cmp_rd_s;
   logic                      wr_act_s;
   logic                      tick_s;

   function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strobe);
      logic [31:0] res;
      res = old_val;
      for (int i = 0; i < 4; i++) begin
         if (strobe[i]) begin
            res[8*i +: 8] = new_val[8*i +: 8];
         end else begin
            res[8*i +: 8] = old_val[8*i +: 8];
         end
      end
      return res;
   endfunction

   // Register views shared by the read mux and the update logic
   always_comb begin
      ctrl_s                        = 32'd0;
      ctrl_s[0]                     = en_q;
      ctrl_s[8 +: PRESCALE_WIDTH]   = prescale_q;
      ctrl_s[16 +: NUM_CMP]         = ie_q;
      cmp_rd_s                      = 32'd0;
      for (int k = 0; k < NUM_CMP; k++) begin
         match_s[k] = (mtime_q >= cmp_q[k]);
         cmp_rd_s   = cmp_rd_s
                    | ((addr == ADDR_WIDTH'(4 + 2 * k)) ? cmp_q[k][31:0]  : 32'd0)
                    | ((addr == ADDR_WIDTH'(5 + 2 * k)) ? cmp_q[k][63:32] : 32'd0);
      end
   end

   // Read mux; always shows pre-edge contents
   always_comb begin
      rd_data = 32'd0;
      if (rd_en) begin
         case (addr)
            ADDR_WIDTH'(0): rd_data = mtime_q[31:0];
            ADDR_WIDTH'(1): rd_data = shadow_q;
            ADDR_WIDTH'(2): rd_data = ctrl_s;
            ADDR_WIDTH'(3): rd_data = 32'(match_s);
            default:        rd_data = cmp_rd_s;
         endcase
      end else begin
         rd_data = 32'd0;
      end
   end

   // Next-state: counter, prescaler, control, shadow, compares, interrupts
   always_comb begin
      wr_act_s    = wr_en && (wr_strobe != 4'b0000);
      tick_s      = en_q && (presc_q == prescale_q);
      ctrl_wr_s   = byte_merge(ctrl_s, wr_data, wr_strobe);
      mtime_d     = mtime_q;
      presc_d     = presc_q;
      en_d        = en_q;
      prescale_d  = prescale_q;
      ie_d        = ie_q;
      shadow_d    = shadow_q;

      // A software write to either half wins over the tick for the whole 64 bits
      if (wr_act_s && (addr == ADDR_WIDTH'(0))) begin
         mtime_d[31:0] = byte_merge(mtime_q[31:0], wr_data, wr_strobe);
      end else if (wr_act_s && (addr == ADDR_WIDTH'(1))) begin
         mtime_d[63:32] = byte_merge(mtime_q[63:32], wr_data, wr_strobe);
      end else if (tick_s) begin
         mtime_d = mtime_q + 64'd1;
      end else begin
         mtime_d = mtime_q;
      end

      if (wr_act_s && (addr == ADDR_WIDTH'(2))) begin
         presc_d    = {PRESCALE_WIDTH{1'b0}};
         en_d       = ctrl_wr_s[0];
         prescale_d = ctrl_wr_s[8 +: PRESCALE_WIDTH];
         ie_d       = ctrl_wr_s[16 +: NUM_CMP];
      end else if (en_q) begin
         presc_d = tick_s ? {PRESCALE_WIDTH{1'b0}} : (presc_q + PRESCALE_WIDTH'(1'b1));
      end else begin
         presc_d = presc_q;
      end

      if (rd_en && (addr == ADDR_WIDTH'(0))) begin
         shadow_d = mtime_q[63:32];
      end else begin
         shadow_d = shadow_q;
      end

      for (int k = 0; k < NUM_CMP; k++) begin
         cmp_d[k] = cmp_q[k];
         if (wr_act_s && (addr == ADDR_WIDTH'(4 + 2 * k))) begin
            cmp_d[k][31:0] = byte_merge(cmp_q[k][31:0], wr_data, wr_strobe);
         end else if (wr_act_s && (addr == ADDR_WIDTH'(5 + 2 * k))) begin
            cmp_d[k][63:32] = byte_merge(cmp_q[k][63:32], wr_data, wr_strobe);
         end else begin
            cmp_d[k] = cmp_q[k];
         end
      end

      int_vec_d   = match_s & ie_q;
      interrupt_d = |int_vec_d;
   end

   // State registers with synchronous reset taking priority over bus access
   always_ff @(posedge clk) begin
      if (rst) begin
         mtime_q     <= 64'd0;
         presc_q     <= {PRESCALE_WIDTH{1'b0}};
         en_q        <= 1'b1;
         prescale_q  <= {PRESCALE_WIDTH{1'b0}};
         ie_q        <= {NUM_CMP{1'b0}};
         shadow_q    <= 32'd0;
         int_vec_q   <= {NUM_CMP{1'b0}};
         interrupt_q <= 1'b0;
         for (int k = 0; k < NUM_CMP; k++) begin
            cmp_q[k] <= 64'hFFFF_FFFF_FFFF_FFFF;
         end
      end else begin
         mtime_q     <= mtime_d;
         presc_q     <= presc_d;
         en_q        <= en_d;
         prescale_q  <= prescale_d;
         ie_q        <= ie_d;
         shadow_q    <= shadow_d;
         int_vec_q   <= int_vec_d;
         interrupt_q <= interrupt_d;
         for (int k = 0; k < NUM_CMP; k++) begin
            cmp_q[k] <= cmp_d[k];
         end
      end
   end

   assign int_vec   = int_vec_q;
   assign interrupt = interrupt_q;

endmodule

// File: tb/tb_mtimer_cluster.sv
// Self-checking bench for mtimer_cluster: directed scenarios plus randomized bus
// traffic compared against a behavioural register-level model.
module tb_mtimer_cluster;
   localparam int NUM_CMP = 2;
   localparam int PW      = 8;
   localparam int AW      = $clog2(4 + 2 * NUM_CMP);

   logic               clk = 1'b0;
   logic               rst, rd_en, wr_en;
   logic [AW-1:0]      addr;
   logic [31:0]        wr_data;
   logic [3:0]         wr_strobe;
   logic [31:0]        rd_data;
   logic [NUM_CMP-1:0] int_vec;
   logic               interrupt;

   always #5 clk = ~clk;

   mtimer_cluster #(.NUM_CMP(NUM_CMP), .PRESCALE_WIDTH(PW)) dut (
      .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .addr(addr),
      .wr_data(wr_data), .wr_strobe(wr_strobe), .rd_data(rd_data),
      .int_vec(int_vec), .interrupt(interrupt)
   );

   int checks = 0;
   int errors = 0;

   // behavioural model state
   logic [63:0]        m_mtime;
   int                 m_presc, m_prescale;
   logic               m_en;
   logic [NUM_CMP-1:0] m_ie, m_int;
   logic [31:0]        m_shadow;
   logic [63:0]        m_cmp [NUM_CMP];
   logic [31:0]        last_rd;
   logic [63:0]        base;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] d,
                                          input logic [3:0] s);
      logic [31:0] r;
      r = o;
      for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
      return r;
   endfunction

   function automatic logic [31:0] model_ctrl();
      return 32'(m_en) | (32'(m_prescale) << 8) | (32'(m_ie) << 16);
   endfunction

   function automatic logic [NUM_CMP-1:0] model_match();
      logic [NUM_CMP-1:0] r;
      for (int k = 0; k < NUM_CMP; k++) r[k] = (m_mtime >= m_cmp[k]);
      return r;
   endfunction

   function automatic logic [31:0] model_read(input int a);
      if (a == 0) return m_mtime[31:0];
      if (a == 1) return m_shadow;
      if (a == 2) return model_ctrl();
      if (a == 3) return 32'(model_match());
      if (a >= 4 && a < 4 + 2 * NUM_CMP)
         return ((a % 2) == 0) ? m_cmp[(a-4)/2][31:0] : m_cmp[(a-4)/2][63:32];
      return 32'd0;
   endfunction

   task automatic model_reset();
      m_mtime = 64'd0; m_presc = 0; m_en = 1'b1; m_prescale = 0;
      m_ie = '0; m_int = '0; m_shadow = 32'd0;
      for (int k = 0; k < NUM_CMP; k++) m_cmp[k] = 64'hFFFF_FFFF_FFFF_FFFF;
   endtask

   task automatic cycle(input logic r, input logic rd, input logic wr, input int a,
                        input logic [31:0] d, input logic [3:0] s);
      logic [63:0]        nm;
      int                 np, npre, k;
      logic               nen, wa, tick;
      logic [NUM_CMP-1:0] nie, nint;
      logic [31:0]        nsh, cw;
      logic [63:0]        ncmp [NUM_CMP];
      rst = r; rd_en = rd; wr_en = wr; addr = AW'(a); wr_data = d; wr_strobe = s;
      #4;
      last_rd = rd_data;
      if (!r) check("rd_data", {32'd0, rd_data}, {32'd0, (rd ? model_read(a) : 32'd0)});
      nint = model_match() & m_ie;
      wa   = wr && (s != 4'b0000);
      tick = m_en && (m_presc == m_prescale);
      nm = m_mtime; np = m_presc; nen = m_en; npre = m_prescale; nie = m_ie; nsh = m_shadow;
      for (int j = 0; j < NUM_CMP; j++) ncmp[j] = m_cmp[j];
      if (rd && a == 0) nsh = m_mtime[63:32];
      if (wa && a == 0)      nm[31:0]  = bmerge(m_mtime[31:0], d, s);
      else if (wa && a == 1) nm[63:32] = bmerge(m_mtime[63:32], d, s);
      else if (tick)         nm = m_mtime + 64'd1;
      if (wa && a == 2) begin
         cw = bmerge(model_ctrl(), d, s);
         np = 0; nen = cw[0]; npre = int'(cw[8 +: PW]); nie = cw[16 +: NUM_CMP];
      end else if (m_en) begin
         np = tick ? 0 : m_presc + 1;
      end
      if (wa && a >= 4 && a < 4 + 2 * NUM_CMP) begin
         k = (a - 4) / 2;
         if ((a % 2) == 0) ncmp[k][31:0]  = bmerge(m_cmp[k][31:0], d, s);
         else              ncmp[k][63:32] = bmerge(m_cmp[k][63:32], d, s);
      end
      @(posedge clk);
      #1;
      if (r) begin
         model_reset();
      end else begin
         m_mtime = nm; m_presc = np; m_en = nen; m_prescale = npre; m_ie = nie;
         m_shadow = nsh; m_int = nint;
         for (int j = 0; j < NUM_CMP; j++) m_cmp[j] = ncmp[j];
      end
      check("int_vec", 64'(int_vec), 64'(m_int));
      check("interrupt", 64'(interrupt), 64'(|m_int));
   endtask

   task automatic idle();
      cycle(1'b0, 1'b0, 1'b0, 0, 32'd0, 4'b0000);
   endtask

   task automatic wr(input int a, input logic [31:0] d);
      cycle(1'b0, 1'b0, 1'b1, a, d, 4'b1111);
   endtask

   task automatic rd(input int a);
      cycle(1'b0, 1'b1, 1'b0, a, 32'd0, 4'b0000);
   endtask

   initial begin
      int unsigned op;
      int          a;
      logic [31:0] d;
      model_reset();
      cycle(1'b1, 1'b0, 1'b0, 0, 32'd0, 4'b0000);
      cycle(1'b1, 1'b0, 1'b1, 2, 32'd0, 4'b1111);
      check("rst_int_vec", 64'(int_vec), 64'd0);

      // free-running count at PRESCALE=0
      repeat (10) idle();
      rd(0);
      check("idle10_lo", 64'(last_rd), 64'd10);
      rd(2);
      check("rst_ctrl", 64'(last_rd), 64'd1);

      // prescaler of 3 gives a tick every 4 cycles
      wr(2, 32'h0000_0301);
      base = m_mtime;
      repeat (40) idle();
      rd(0);
      check("presc3_delta", 64'(last_rd - base[31:0]), 64'd10);

      // carry into the high word and shadow consistency
      wr(2, 32'h0000_0001);
      wr(0, 32'hFFFF_FFFE);
      wr(1, 32'h0000_0000);
      idle(); idle();
      rd(0);
      check("carry_lo", 64'(last_rd), 64'd0);
      rd(1);
      check("carry_hi_shadow", 64'(last_rd), 64'd1);

      // compare channel 1 at 5
      wr(2, 32'h0000_0000);
      wr(0, 32'd0); wr(1, 32'd0);
      wr(7, 32'd0); wr(6, 32'd5);
      wr(2, 32'h0002_0001);
      repeat (8) idle();
      check("cmp1_int_vec", 64'(int_vec), 64'h2);
      check("cmp1_interrupt", 64'(interrupt), 64'd1);
      rd(3);
      check("cmp1_status", 64'(last_rd), 64'h2);
      wr(6, 32'd100);
      idle();
      check("cmp1_cleared", 64'(int_vec), 64'd0);

      // 64-bit wrap with channel 0 at zero
      wr(2, 32'h0000_0000);
      wr(0, 32'hFFFF_FFFF); wr(1, 32'hFFFF_FFFF);
      wr(4, 32'd0); wr(5, 32'd0);
      wr(2, 32'h0001_0001);
      idle();
      rd(0);
      check("wrap_lo", 64'(last_rd), 64'd0);
      rd(1);
      check("wrap_hi", 64'(last_rd), 64'd0);
      check("wrap_int0", 64'(int_vec[0]), 64'd1);

      // partial byte write concurrent with a tick, then reset mid-run
      wr(2, 32'h0000_0001);
      wr(0, 32'h1234_5600);
      cycle(1'b0, 1'b0, 1'b1, 0, 32'h0000_00AB, 4'b0001);
      rd(0);
      check("byte0_write", 64'(last_rd), 64'h1234_56AB);
      cycle(1'b0, 1'b0, 1'b1, 0, 32'hDEAD_BEEF, 4'b0000);
      cycle(1'b1, 1'b0, 1'b1, 0, 32'h5555_5555, 4'b1111);
      check("midrst_int", 64'(int_vec), 64'd0);
      rd(0);
      check("midrst_lo", 64'(last_rd), 64'd0);
      rd(4);
      check("midrst_cmp", 64'(last_rd), 64'hFFFF_FFFF);

      // randomized traffic
      for (int n = 0; n < 800; n++) begin
         op = $urandom_range(0, 99);
         a  = int'($urandom_range(0, (1 << AW) - 1));
         if (a == 2)
            d = ($urandom & 32'h0003_0301) | 32'(($urandom_range(0, 3) != 0) ? 1 : 0);
         else if ($urandom_range(0, 3) == 0)
            d = $urandom;
         else
            d = $urandom_range(0, 200);
         if (op < 1)       cycle(1'b1, 1'b0, 1'b0, a, d, 4'b1111);
         else if (op < 35) idle();
         else if (op < 65) rd(a);
         else if (op < 92) cycle(1'b0, 1'b0, 1'b1, a, d, 4'($urandom_range(0, 15)));
         else              cycle(1'b0, 1'b1, 1'b1, a, d, 4'($urandom_range(0, 15)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
